// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequencer between register read and a combinational ALU. It accepts one
// MIPS instruction and its two register operands over a valid/ready
// handshake. It decodes the instruction into the ALU's internal
// operand/funct encoding and drives the ALU for one cycle. It then captures
// the result and returns it with the destination register index over a
// second valid/ready handshake. It also flags unsupported instructions and
// keeps a saturating count of completed operations.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    instruction handshake (in_ready = IDLE only)
//   instr, rs_data,        instruction word and its rs/rt register values
//   rt_data
//   alu_data1, alu_data2,  registered ALU operands, shift amount and
//   alu_shamt, alu_funct   internal funct code
//   alu_result             combinational ALU result, sampled in EXEC
//   out_valid / out_ready  result handshake
//   out_result, out_dest,  captured result, destination register index,
//   out_illegal            and the unsupported-instruction flag
//   retired_cnt            completed result handshakes, saturating
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [31:0]      alu_data1,
  output logic [31:0]      alu_data2,
  output logic [4:0]       alu_shamt,
  output logic [5:0]       alu_funct,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_dest,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  // ALU internal funct codes.
  localparam logic [5:0] ALU_ADDU = 6'b001001;
  localparam logic [5:0] ALU_SUBU = 6'b001010;
  localparam logic [5:0] ALU_SLL  = 6'b100001;
  localparam logic [5:0] ALU_SLLV = 6'b110101;
  localparam logic [5:0] ALU_SLTI = 6'b101010;
  localparam logic [5:0] ALU_NONE = 6'b000000;

  // MIPS opcode / funct values that are supported.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SLLV  = 6'b000100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_alu_data1;
  logic [31:0]      r_alu_data2;
  logic [4:0]       r_alu_shamt;
  logic [5:0]       r_alu_funct;
  logic [31:0]      r_out_result;
  logic [4:0]       r_out_dest;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_retired_cnt;

  // Instruction fields.
  logic [5:0]  w_opcode;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt_fld;
  logic [5:0]  w_funct_fld;
  logic [15:0] w_imm;

  assign w_opcode    = instr[31:26];
  assign w_rt        = instr[20:16];
  assign w_rd        = instr[15:11];
  assign w_shamt_fld = instr[10:6];
  assign w_funct_fld = instr[5:0];
  assign w_imm       = instr[15:0];

  // Decoded values, loaded into the ALU registers only on acceptance.
  logic [5:0]  w_dec_funct;
  logic [31:0] w_dec_d1;
  logic [31:0] w_dec_d2;
  logic [4:0]  w_dec_shamt;
  logic [4:0]  w_dec_dest;
  logic        w_dec_illegal;

  logic w_accept;
  logic w_retire;

  // NOTE: every signal assigned in an always_comb gets a default first so that
  // no path leaves it unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_dec_funct   = ALU_NONE;
    w_dec_d1      = '0;
    w_dec_d2      = '0;
    w_dec_shamt   = '0;
    w_dec_dest    = '0;
    w_dec_illegal = 1'b1;
    if (w_opcode == OP_RTYPE) begin
      case (w_funct_fld)
        FN_ADDU: begin
          w_dec_funct   = ALU_ADDU;
          w_dec_d1      = rs_data;
          w_dec_d2      = rt_data;
          w_dec_dest    = w_rd;
          w_dec_illegal = 1'b0;
        end
        FN_SUBU: begin
          w_dec_funct   = ALU_SUBU;
          w_dec_d1      = rs_data;
          w_dec_d2      = rt_data;
          w_dec_dest    = w_rd;
          w_dec_illegal = 1'b0;
        end
        FN_SLL: begin
          w_dec_funct   = ALU_SLL;
          w_dec_d1      = rt_data;
          w_dec_shamt   = w_shamt_fld;
          w_dec_dest    = w_rd;
          w_dec_illegal = 1'b0;
        end
        FN_SLLV: begin
          w_dec_funct   = ALU_SLLV;
          w_dec_d1      = rt_data;
          w_dec_d2      = rs_data;
          w_dec_dest    = w_rd;
          w_dec_illegal = 1'b0;
        end
        default: ;
      endcase
    end else if (w_opcode == OP_SLTI) begin
      // The ALU compare is unsigned; the immediate is still sign-extended and
      // the result is used as the ALU produces it.
      w_dec_funct   = ALU_SLTI;
      w_dec_d1      = rs_data;
      w_dec_d2      = {{16{w_imm[15]}}, w_imm};
      w_dec_dest    = w_rt;
      w_dec_illegal = 1'b0;
    end
  end

  // Handshake qualifiers depend on state only, not on the other side.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_retire  = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever order the
  // statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: all datapath registers are reset. Reset in EXEC/DONE must drop the
  // instruction and return every output to a known value at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_data1   <= '0;
      r_alu_data2   <= '0;
      r_alu_shamt   <= '0;
      r_alu_funct   <= ALU_NONE;
      r_out_dest    <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_data1   <= w_dec_d1;
      r_alu_data2   <= w_dec_d2;
      r_alu_shamt   <= w_dec_shamt;
      r_alu_funct   <= w_dec_funct;
      r_out_dest    <= w_dec_dest;
      r_out_illegal <= w_dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_out_result <= '0;
    else if (r_state == S_EXEC) r_out_result <= alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
    end else if (w_retire && (r_retired_cnt != {CNT_W{1'b1}})) begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign alu_data1   = r_alu_data1;
  assign alu_data2   = r_alu_data2;
  assign alu_shamt   = r_alu_shamt;
  assign alu_funct   = r_alu_funct;
  assign out_result  = r_out_result;
  assign out_dest    = r_out_dest;
  assign out_illegal = r_out_illegal;
  assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed bench for alu_issue_ctrl. A behavioural ALU drives alu_result from
// the block's ALU outputs. A second instance with CNT_W=2 shares every input
// and is used for the saturating-counter case. Inputs are driven and outputs
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic        out_illegal;
  logic [15:0] retired_cnt;

  // Saturation instance (only the counter is checked, other outputs unused).
  logic        s_in_ready;
  logic [31:0] s_alu_data1;
  logic [31:0] s_alu_data2;
  logic [4:0]  s_alu_shamt;
  logic [5:0]  s_alu_funct;
  logic        s_out_valid;
  logic [31:0] s_out_result;
  logic [4:0]  s_out_dest;
  logic        s_out_illegal;
  logic [1:0]  s_retired_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  alu_issue_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .out_illegal(out_illegal), .retired_cnt(retired_cnt)
  );

  alu_issue_ctrl #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_data1(s_alu_data1), .alu_data2(s_alu_data2),
    .alu_shamt(s_alu_shamt), .alu_funct(s_alu_funct),
    .alu_result(alu_result),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_dest(s_out_dest),
    .out_illegal(s_out_illegal), .retired_cnt(s_retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: unsigned compare, unknown codes give 0.
  always_comb begin
    alu_result = '0;
    case (alu_funct)
      6'b001001: alu_result = alu_data1 + alu_data2;
      6'b001010: alu_result = alu_data1 - alu_data2;
      6'b100001: alu_result = alu_data1 << alu_shamt;
      6'b110101: alu_result = alu_data1 << alu_data2[4:0];
      6'b101010: alu_result = (alu_data1 < alu_data2) ? 32'd1 : 32'd0;
      default:   alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, check EXEC-cycle ALU drive and DONE-cycle result,
  // optionally stall in DONE, then complete the result handshake.
  task automatic issue(input string tag, input logic [31:0] i_w,
                       input logic [31:0] rs_v, input logic [31:0] rt_v,
                       input logic [5:0] e_fn, input logic [31:0] e_d1,
                       input logic [31:0] e_d2, input logic [4:0] e_sh,
                       input logic [31:0] e_res, input logic [4:0] e_dest,
                       input logic e_ill, input int stall);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    instr    = i_w;
    rs_data  = rs_v;
    rt_data  = rt_v;
    in_valid = 1'b1;
    tick();                         // acceptance edge T
    in_valid = 1'b0;
    instr    = 32'hDEAD_BEEF;
    rs_data  = 32'h1111_1111;
    rt_data  = 32'h2222_2222;
    check({tag, ".exec_funct"}, {26'd0, alu_funct}, {26'd0, e_fn});
    check({tag, ".exec_d1"}, alu_data1, e_d1);
    check({tag, ".exec_d2"}, alu_data2, e_d2);
    check({tag, ".exec_shamt"}, {27'd0, alu_shamt}, {27'd0, e_sh});
    check({tag, ".exec_ovalid"}, {31'd0, out_valid}, 32'd0);
    tick();                         // T+1: DONE
    check({tag, ".ovalid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"}, out_result, e_res);
    check({tag, ".dest"}, {27'd0, out_dest}, {27'd0, e_dest});
    check({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
    for (int k = 0; k < stall; k++) begin
      // A fresh instruction is offered while the result waits; it must be ignored.
      instr    = r_type(5'd1, 5'd2, 5'd7, 5'd0, 6'b100001);
      in_valid = (k % 2 == 0);
      tick();
      check({tag, ".stall_ovalid"}, {31'd0, out_valid}, 32'd1);
      check({tag, ".stall_inrdy"}, {31'd0, in_ready}, 32'd0);
      check({tag, ".stall_result"}, out_result, e_res);
      check({tag, ".stall_dest"}, {27'd0, out_dest}, {27'd0, e_dest});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();                         // handshake edge D
    out_ready = 1'b0;
    exp_cnt++;
    check({tag, ".back_idle"}, {31'd0, in_ready}, 32'd1);
    check({tag, ".done_ovalid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".retired"}, {16'd0, retired_cnt}, exp_cnt);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    rs_data   = '0;
    rt_data   = '0;
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.alu_funct", {26'd0, alu_funct}, 32'd0);
    check("rst.retired", {16'd0, retired_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst.alu_data1", alu_data1, 32'd0);
    check("rst.out_result", out_result, 32'd0);

    issue("addu", r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'd5, 32'd7,
          6'b001001, 32'd5, 32'd7, 5'd0, 32'd12, 5'd3, 1'b0, 0);
    issue("subu", r_type(5'd4, 5'd5, 5'd6, 5'd0, 6'b100011), 32'd3, 32'd5,
          6'b001010, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 5'd6, 1'b0, 0);
    issue("sll", r_type(5'd0, 5'd8, 5'd10, 5'd4, 6'b000000), 32'd99, 32'd1,
          6'b100001, 32'd1, 32'd0, 5'd4, 32'h10, 5'd10, 1'b0, 0);
    issue("sllv", r_type(5'd2, 5'd3, 5'd11, 5'd7, 6'b000100), 32'h24, 32'd1,
          6'b110101, 32'd1, 32'h24, 5'd0, 32'h10, 5'd11, 1'b0, 0);
    check("sat.after4", {30'd0, s_retired_cnt}, 32'd3);
    issue("slti_neg", i_type(6'b001010, 5'd1, 5'd9, 16'hFFFF), 32'd3, 32'd0,
          6'b101010, 32'd3, 32'hFFFF_FFFF, 5'd0, 32'd1, 5'd9, 1'b0, 0);
    issue("slti_pos", i_type(6'b001010, 5'd1, 5'd9, 16'h0002), 32'd3, 32'd0,
          6'b101010, 32'd3, 32'd2, 5'd0, 32'd0, 5'd9, 1'b0, 0);
    issue("lw", i_type(6'b100011, 5'd1, 5'd9, 16'h0010), 32'd3, 32'd4,
          6'b000000, 32'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1'b1, 0);
    issue("stall", r_type(5'd1, 5'd2, 5'd12, 5'd0, 6'b100001), 32'd100, 32'd23,
          6'b001001, 32'd100, 32'd23, 5'd0, 32'd123, 5'd12, 1'b0, 5);
    // Operands held after completion until the next acceptance.
    tick();
    check("hold.alu_data1", alu_data1, 32'd100);
    check("sat.after8", {30'd0, s_retired_cnt}, 32'd3);

    // Reset in EXEC: instruction dropped, outputs reset at once.
    instr    = r_type(5'd1, 5'd2, 5'd13, 5'd0, 6'b100001);
    rs_data  = 32'd1;
    rt_data  = 32'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rexec.pre_funct", {26'd0, alu_funct}, 32'h09);
    rst_n = 1'b0;
    #1;
    check("rexec.in_ready", {31'd0, in_ready}, 32'd1);
    check("rexec.out_valid", {31'd0, out_valid}, 32'd0);
    check("rexec.alu_funct", {26'd0, alu_funct}, 32'd0);
    check("rexec.alu_data1", alu_data1, 32'd0);
    check("rexec.out_result", out_result, 32'd0);
    check("rexec.out_dest", {27'd0, out_dest}, 32'd0);
    check("rexec.retired", {16'd0, retired_cnt}, 32'd0);
    tick();
    tick();
    rst_n   = 1'b1;
    exp_cnt = 0;
    tick();
    check("rexec.after_ovalid", {31'd0, out_valid}, 32'd0);

    // Five completions after reset: wide counter 5, 2-bit counter saturates at 3.
    for (int n = 0; n < 5; n++) begin
      issue("sat_op", r_type(5'd1, 5'd2, 5'd1, 5'd0, 6'b100001), n, 32'd1,
            6'b001001, n, 32'd1, 5'd0, n + 1, 5'd1, 1'b0, 0);
    end
    check("sat.wide", {16'd0, retired_cnt}, 32'd5);
    check("sat.narrow", {30'd0, s_retired_cnt}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer that sits between instruction fetch/register read and the combinational ALU. It accepts one MIPS instruction plus its two register operands over a valid/ready handshake, and decodes it into the ALU's internal operand/funct encoding. It drives the ALU for one cycle, captures the result, and returns it with its destination register index over a second valid/ready handshake. It also flags unsupported instructions and counts retired operations.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  instruction/operands valid
- in_ready  output  1  block can accept an instruction
- instr  input  32  MIPS instruction word
- rs_data  input  32  value of register rs
- rt_data  input  32  value of register rt
- alu_data1  output  32  ALU operand 1 (registered)
- alu_data2  output  32  ALU operand 2 (registered)
- alu_shamt  output  5  ALU shift amount (registered)
- alu_funct  output  6  ALU internal funct code (registered)
- alu_result  input  32  combinational ALU result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  32  captured ALU result
- out_dest  output  5  destination register index
- out_illegal  output  1  instruction unsupported
- retired_cnt  output  CNT_W  completed handshakes, saturating

## Operation
- Fields: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- ALU codes are fixed: ADDU 001001, SUBU 001010, SLL 100001, SLLV 110101, SLTI 101010. Any other code makes the ALU produce 0.
- Decode, sampled only on acceptance (in_valid && in_ready):
  - opcode 000000, funct 100001 (addu): code ADDU, d1=rs_data, d2=rt_data, dest=rd.
  - opcode 000000, funct 100011 (subu): code SUBU, d1=rs_data, d2=rt_data, dest=rd.
  - opcode 000000, funct 000000 (sll): code SLL, d1=rt_data, d2=0, shamt=instr shamt, dest=rd.
  - opcode 000000, funct 000100 (sllv): code SLLV, d1=rt_data, d2=rs_data, dest=rd.
  - opcode 001010 (slti): code SLTI, d1=rs_data, d2={{16{imm[15]}},imm}, dest=rt.
  - All else: code 000000, d1=d2=0, shamt=0, dest=0, illegal=1.
- shamt field is driven to 0 for every non-SLL op.
- The ALU compare is unsigned. slti is issued with a sign-extended immediate; no correction is applied.
- FSM states:
  - IDLE: in_ready=1. On acceptance, load operand/funct/dest/illegal registers and go to EXEC.
  - EXEC: ALU inputs are stable. At the end of the cycle, capture alu_result into out_result and go to DONE.
  - DONE: out_valid=1; all out_* held stable. When out_ready=1, return to IDLE and increment retired_cnt (saturating at all-ones).
- Illegal instructions still traverse EXEC/DONE and are counted.
- ALU operand registers hold their values after EXEC until the next acceptance.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, alu_data1/alu_data2/out_result=0, alu_shamt=0, alu_funct=000000, out_dest=0, out_illegal=0, retired_cnt=0.
- Acceptance edge T → EXEC during T+1 → out_valid=1 from T+2. Minimum initiation interval is 3 cycles.
- in_ready is combinational from state only (IDLE). It never depends on in_valid or out_ready.
- No new acceptance while in EXEC or DONE. instr and operands are ignored there.
- out_valid, once high, stays high with unchanged data until the cycle out_ready=1 is sampled.
- Back-to-back: the handshake at DONE edge D returns to IDLE, so the next acceptance is possible at edge D+1.
- Reset asserted in EXEC or DONE: the instruction is discarded, all outputs return to reset values immediately, and the counter is not incremented.

## Test plan
- addu rs_data=5, rt_data=7, rd=3 → alu_funct=001001 in EXEC; out_result=12, out_dest=3, out_illegal=0; out_valid 2 cycles after acceptance.
- subu rs_data=3, rt_data=5 → out_result=0xFFFFFFFE. sll rt_data=1, shamt=4 → alu_shamt=4, out_result=0x10. sllv rs_data=0x24, rt_data=1 → out_result=0x10 (shift by rs[4:0]=4).
- slti rs_data=3, imm=0xFFFF, rt=9 → alu_data2=0xFFFFFFFF, out_result=1, out_dest=9. Then imm=0x0002 → out_result=0.
- opcode 100011 (lw) → alu_funct=000000, out_result=0, out_illegal=1, retired_cnt increments.
- out_ready held low 5 cycles in DONE → out_* stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next cycle, retired_cnt+1.
- rst_n pulsed low during EXEC → all outputs at reset values that cycle. With CNT_W=2, 5 completed ops → retired_cnt=3 (saturated).
